// File: rtl/codec_init_seq.sv
// WM8731 power-up register sequencer: walks an 11-entry init table over an
// external I2C write engine, then services headphone volume updates.
module codec_init_seq #(
    parameter logic [7:0]  I2C_ADDR  = 8'h34,
    parameter logic [15:0] START_DLY = 16'd1000,
    parameter logic [7:0]  GAP_CYC   = 8'd20,
    parameter logic [15:0] ACK_TO    = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        vol_req,
    input  logic [6:0]  vol_val,
    output logic        vol_ack,
    input  logic        i2c_idle,
    output logic [23:0] i2c_packet,
    output logic        wr_i2c,
    output logic        init_done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DLY       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACC  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    // {reg[6:0], data[8:0]}; entry 0 resets the codec, entry 10 activates it.
    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    init_entry = {7'd15, 9'h000};
            4'd1:    init_entry = {7'd6,  9'h010};
            4'd2:    init_entry = {7'd0,  9'h017};
            4'd3:    init_entry = {7'd1,  9'h017};
            4'd4:    init_entry = {7'd2,  9'h179};
            4'd5:    init_entry = {7'd3,  9'h079};
            4'd6:    init_entry = {7'd4,  9'h012};
            4'd7:    init_entry = {7'd5,  9'h000};
            4'd8:    init_entry = {7'd7,  9'h00A};
            4'd9:    init_entry = {7'd8,  9'h000};
            4'd10:   init_entry = {7'd9,  9'h001};
            default: init_entry = {7'd9,  9'h001};
        endcase
    endfunction

    state_t        state_r, state_s;
    logic [15:0]   cnt_r, cnt_s;
    logic [16:0]   cnt_inc_s;
    logic [3:0]    idx_r, idx_s;
    logic          vol_mode_r, vol_mode_s;
    logic [6:0]    vol_data_r, vol_data_s;
    logic [23:0]   packet_r, packet_s;
    logic          wr_r, wr_s;
    logic          vol_ack_r, vol_ack_s;
    logic          init_done_r, err_r, busy_r;

    assign cnt_inc_s = {1'b0, cnt_r} + 17'd1;

    // Next-state, counter, index and strobe decode.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        vol_mode_s = vol_mode_r;
        vol_data_s = vol_data_r;
        packet_s   = packet_r;
        wr_s       = 1'b0;
        vol_ack_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_DLY;
                cnt_s   = 16'd0;
            end
            ST_DLY: begin
                if (cnt_inc_s >= {1'b0, START_DLY}) begin
                    state_s = ST_ISSUE;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s = cnt_inc_s[15:0];
                end
            end
            ST_ISSUE: begin
                if (i2c_idle) begin
                    wr_s    = 1'b1;
                    state_s = ST_WAIT_ACC;
                    cnt_s   = 16'd0;
                    if (vol_mode_r) begin
                        packet_s = {I2C_ADDR, 7'd2, 1'b1, 1'b0, vol_data_r};
                    end else begin
                        packet_s = {I2C_ADDR, init_entry(idx_r)};
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT_ACC: begin
                // The engine must show it accepted the strobe by leaving idle.
                if (!i2c_idle) begin
                    state_s = ST_WAIT_DONE;
                    cnt_s   = 16'd0;
                end else if (cnt_inc_s >= {1'b0, ACK_TO}) begin
                    state_s = ST_ERR;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s = cnt_inc_s[15:0];
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_idle) begin
                    state_s = ST_GAP;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (cnt_inc_s >= {9'd0, GAP_CYC}) begin
                    cnt_s = 16'd0;
                    if (vol_mode_r) begin
                        state_s    = ST_DONE;
                        vol_mode_s = 1'b0;
                        vol_ack_s  = 1'b1;
                    end else if (idx_r < LAST_IDX) begin
                        state_s = ST_ISSUE;
                        idx_s   = idx_r + 4'd1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    cnt_s = cnt_inc_s[15:0];
                end
            end
            ST_DONE: begin
                // A restart outranks a pending volume request.
                if (start) begin
                    state_s    = ST_ISSUE;
                    idx_s      = 4'd0;
                    cnt_s      = 16'd0;
                    vol_mode_s = 1'b0;
                end else if (vol_req) begin
                    state_s    = ST_ISSUE;
                    cnt_s      = 16'd0;
                    vol_mode_s = 1'b1;
                    vol_data_s = vol_val;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_s    = ST_ISSUE;
                    idx_s      = 4'd0;
                    cnt_s      = 16'd0;
                    vol_mode_s = 1'b0;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
                idx_s   = 4'd0;
            end
        endcase
    end

    // State and output registers; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            idx_r       <= 4'd0;
            vol_mode_r  <= 1'b0;
            vol_data_r  <= 7'd0;
            packet_r    <= 24'h0;
            wr_r        <= 1'b0;
            vol_ack_r   <= 1'b0;
            init_done_r <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            vol_mode_r  <= vol_mode_s;
            vol_data_r  <= vol_data_s;
            packet_r    <= packet_s;
            wr_r        <= wr_s;
            vol_ack_r   <= vol_ack_s;
            init_done_r <= (state_s == ST_DONE);
            err_r       <= (state_s == ST_ERR);
            busy_r      <= (state_s != ST_DONE) && (state_s != ST_ERR);
        end
    end

    assign i2c_packet = packet_r;
    assign wr_i2c     = wr_r;
    assign vol_ack    = vol_ack_r;
    assign init_done  = init_done_r;
    assign err        = err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_codec_init_seq.sv
// Self-checking bench for codec_init_seq: behavioural I2C engine, spec-table
// reference packets, volume vector table plus randomized volume writes.
module tb_codec_init_seq;

    localparam logic [7:0]  ADDR   = 8'h34;
    localparam logic [15:0] SDLY   = 16'd40;
    localparam logic [7:0]  GAP    = 8'd5;
    localparam logic [15:0] ACKTO  = 16'd100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        vol_req;
    logic [6:0]  vol_val;
    logic        vol_ack;
    logic        i2c_idle;
    logic [23:0] i2c_packet;
    logic        wr_i2c;
    logic        init_done;
    logic        busy;
    logic        err;

    codec_init_seq #(
        .I2C_ADDR(ADDR), .START_DLY(SDLY), .GAP_CYC(GAP), .ACK_TO(ACKTO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vol_req(vol_req),
        .vol_val(vol_val), .vol_ack(vol_ack), .i2c_idle(i2c_idle),
        .i2c_packet(i2c_packet), .wr_i2c(wr_i2c), .init_done(init_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] rg; logic [8:0] dt; } init_ent_t;
    typedef struct { logic [6:0] vol; logic [23:0] pk; } vol_vec_t;

    init_ent_t   itab [11];
    vol_vec_t    vtab [4];

    int          checks = 0;
    int          errors = 0;

    // I2C engine model state (owned by the model process)
    int          cyc = 0;
    int          busy_cnt = 0;
    int          viol = 0;
    logic        prev_wr = 1'b0;
    logic [23:0] pk_q [$];
    int          cyc_q [$];
    // model controls (owned by the main process)
    int          busy_len = 50;
    logic        stuck = 1'b0;
    logic        hold_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] vol_pkt(input logic [6:0] v);
        return {ADDR, 7'd2, 1'b1, 1'b0, v};
    endfunction

    // I2C engine: leaves idle one cycle after each strobe for busy_len cycles.
    initial begin
        i2c_idle = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (wr_i2c) begin
                if (prev_wr) viol++;
                pk_q.push_back(i2c_packet);
                cyc_q.push_back(cyc);
                if (!stuck) busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            prev_wr  = wr_i2c;
            i2c_idle = !(hold_low || busy_cnt > 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int acks);
        int n;
        n = 0;
        acks = 0;
        while (!init_done && n < 4000) begin
            @(negedge clk);
            if (vol_ack) acks++;
            n++;
        end
        chk(name, init_done, 1);
    endtask

    task automatic check_init(input string name, input int base);
        chk($sformatf("%s_count", name), pk_q.size() - base, 11);
        for (int i = 0; i < 11; i++) begin
            if (base + i < pk_q.size())
                chk($sformatf("%s_pk%0d", name, i), pk_q[base + i], {ADDR, itab[i].rg, itab[i].dt});
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_wr"}, wr_i2c, 0);
        chk({name, "_pk"}, i2c_packet, 0);
        chk({name, "_done"}, init_done, 0);
        chk({name, "_ack"}, vol_ack, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_busy"}, busy, 1);
    endtask

    task automatic vol_write(input string name, input logic [6:0] v, input logic [23:0] exp_pk);
        int n0, n;
        n0 = pk_q.size();
        n = 0;
        vol_val = v;
        vol_req = 1'b1;
        while (!vol_ack && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vol_req = 1'b0;
        chk({name, "_ack"}, vol_ack, 1);
        chk({name, "_strobes"}, pk_q.size() - n0, 1);
        if (pk_q.size() > n0) chk({name, "_pk"}, pk_q[n0], exp_pk);
        @(negedge clk);
        chk({name, "_ack_width"}, vol_ack, 0);
        chk({name, "_done"}, init_done, 1);
    endtask

    initial begin
        int base, n0, n, acks, rel, err_cyc;
        logic [6:0] rv;

        itab[0]  = '{7'd15, 9'h000};  itab[1]  = '{7'd6, 9'h010};
        itab[2]  = '{7'd0,  9'h017};  itab[3]  = '{7'd1, 9'h017};
        itab[4]  = '{7'd2,  9'h179};  itab[5]  = '{7'd3, 9'h079};
        itab[6]  = '{7'd4,  9'h012};  itab[7]  = '{7'd5, 9'h000};
        itab[8]  = '{7'd7,  9'h00A};  itab[9]  = '{7'd8, 9'h000};
        itab[10] = '{7'd9,  9'h001};
        vtab[0]  = '{7'h60, 24'h340560};
        vtab[1]  = '{7'h00, 24'h340500};
        vtab[2]  = '{7'h7F, 24'h34057F};
        vtab[3]  = '{7'h30, 24'h340530};

        reset = 1'b0; start = 1'b0; vol_req = 1'b0; vol_val = 7'd0;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst");

        // power-up sequence
        reset = 1'b1;
        base = cyc;
        n0 = pk_q.size();
        wait_done("init_done", acks);
        check_init("init", n0);
        if (cyc_q.size() > n0) chk("first_strobe_cyc", cyc_q[n0] - base, SDLY + 2);
        chk("init_last_pk", pk_q[pk_q.size() - 1], 24'h341201);
        chk("init_busy", busy, 0);
        chk("init_err", err, 0);

        // volume vectors
        for (int i = 0; i < 4; i++)
            vol_write($sformatf("vol%0d", i), vtab[i].vol, vtab[i].pk);

        // randomized volume codes and engine latencies
        for (int i = 0; i < 6; i++) begin
            busy_len = $urandom_range(60, 3);
            rv = 7'($urandom);
            vol_write($sformatf("rvol%0d", i), rv, vol_pkt(rv));
        end
        busy_len = 50;

        // start and vol_req together: restart wins, no vol_ack
        n0 = pk_q.size();
        vol_val = 7'h11;
        vol_req = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vol_req = 1'b0;
        chk("coin_done_low", init_done, 0);
        chk("coin_busy", busy, 1);
        wait_done("coin_done", acks);
        chk("coin_no_ack", acks, 0);
        check_init("coin", n0);

        // engine not idle on entry to ISSUE
        hold_low = 1'b1;
        @(negedge clk);
        n0 = pk_q.size();
        pulse_start();
        repeat (30) @(negedge clk);
        chk("hold_no_strobe", pk_q.size() - n0, 0);
        hold_low = 1'b0;
        rel = cyc;
        n = 0;
        while (pk_q.size() == n0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_strobed", pk_q.size() > n0, 1);
        if (pk_q.size() > n0) chk("hold_strobe_cyc", cyc_q[n0] - rel, 2);
        wait_done("hold_done", acks);
        check_init("hold", n0);

        // engine never leaves idle -> timeout
        stuck = 1'b1;
        n0 = pk_q.size();
        pulse_start();
        n = 0;
        while (!err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        chk("to_err", err, 1);
        chk("to_strobes", pk_q.size() - n0, 1);
        if (cyc_q.size() > n0) chk("to_err_cyc", err_cyc - cyc_q[n0], ACKTO);
        chk("to_busy", busy, 0);
        chk("to_done", init_done, 0);
        repeat (10) @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_no_strobe", pk_q.size() - n0, 1);
        stuck = 1'b0;
        n0 = pk_q.size();
        pulse_start();
        chk("err_cleared", err, 0);
        wait_done("recover_done", acks);
        check_init("recover", n0);

        // reset during WAIT_DONE of entry 5
        n0 = pk_q.size();
        pulse_start();
        n = 0;
        while (pk_q.size() < n0 + 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached5", pk_q.size() - n0, 6);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        n = pk_q.size();
        repeat (5) @(negedge clk);
        chk("mid_rst_no_strobe", pk_q.size() - n, 0);
        reset = 1'b1;
        base = cyc;
        n0 = pk_q.size();
        wait_done("mid_done", acks);
        check_init("mid", n0);
        if (cyc_q.size() > n0) chk("mid_first_cyc", cyc_q[n0] - base, SDLY + 2);

        chk("no_back_to_back", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 SHALL provide parameter I2C_ADDR, default 8'h34, the WM8731 7-bit address plus write bit.
REQ-002 SHALL provide parameter START_DLY, default 16'd1000, the clk cycles from reset release to the first write.
REQ-003 SHALL provide parameter GAP_CYC, default 8'd20, the idle clk cycles between consecutive writes.
REQ-004 SHALL provide parameter ACK_TO, default 16'd4096, the clk cycles allowed for the I2C engine to drop i2c_idle after wr_i2c.
REQ-005 SHALL have ports:
 clk  in  1  system clock, all logic rising-edge
 reset  in  1  synchronous, active-low reset
 start  in  1  one-cycle pulse, re-runs the full init sequence
 vol_req  in  1  request a headphone volume write
 vol_val  in  7  headphone volume code, held with vol_req
 vol_ack  out  1  one-cycle pulse, volume write finished
 i2c_idle  in  1  I2C engine idle
 i2c_packet  out  24  {I2C_ADDR, reg[6:0], data[8:0]}
 wr_i2c  out  1  one-cycle write strobe to the I2C engine
 init_done  out  1  sequence complete, codec active
 busy  out  1  sequencer in any state other than DONE or ERR
 err  out  1  timeout occurred, sticky

Function
REQ-006 SHALL contain an 11-entry table, index 0..10: R15=0x000 (reset), R6=0x010, R0=0x017, R1=0x017, R2=0x179, R3=0x079, R4=0x012, R5=0x000, R7=0x00A, R8=0x000, R9=0x001 (active).
REQ-007 SHALL implement states IDLE, DLY, ISSUE, WAIT_ACC, WAIT_DONE, GAP, DONE, ERR.
REQ-008 SHALL move from IDLE to DLY on the first cycle after reset release, and SHALL move from DLY to ISSUE after exactly START_DLY cycles.
REQ-009 In ISSUE, if i2c_idle=1, SHALL assert wr_i2c for exactly one cycle with i2c_packet={I2C_ADDR, table[idx]}, then go to WAIT_ACC.
REQ-010 In ISSUE, if i2c_idle=0, SHALL hold without strobing until i2c_idle=1.
REQ-011 SHALL hold i2c_packet stable from the strobe cycle until WAIT_DONE exits.
REQ-012 In WAIT_ACC, SHALL go to WAIT_DONE on i2c_idle=0; if i2c_idle stays 1 for ACK_TO cycles, SHALL go to ERR.
REQ-013 In WAIT_DONE, SHALL go to GAP on i2c_idle=1; the wait has no timeout.
REQ-014 GAP SHALL last GAP_CYC cycles; then, if idx<10, SHALL increment idx and return to ISSUE; if idx=10, SHALL go to DONE.
REQ-015 In DONE, SHALL hold init_done=1; it is 0 in every other state.
REQ-016 In DONE, vol_req=1 SHALL latch vol_val and issue one write with reg=7'd2, data={1'b1, 1'b0, vol_val} (LRHPBOTH=1), using the ISSUE/WAIT_ACC/WAIT_DONE/GAP path.
REQ-017 After GAP, a volume write SHALL return to DONE and pulse vol_ack for one cycle.
REQ-018 vol_req outside DONE SHALL be ignored; the requester holds it until vol_ack.
REQ-019 start in DONE or ERR SHALL clear err, set idx=0, and go to ISSUE, skipping DLY; start in any other state SHALL be ignored.
REQ-020 When start and vol_req coincide in DONE, start SHALL win and vol_ack SHALL NOT pulse.
REQ-021 In ERR, SHALL hold err=1 with wr_i2c=0 until start.
REQ-022 busy SHALL be 1 in IDLE, DLY, ISSUE, WAIT_ACC, WAIT_DONE and GAP.
REQ-023 wr_i2c SHALL never be asserted on two consecutive cycles.

Reset
REQ-024 While reset=0, SHALL force state=IDLE, idx=0, all counters=0, wr_i2c=0, i2c_packet=24'h0, init_done=0, vol_ack=0, err=0, busy=1.
REQ-025 reset=0 mid-transaction SHALL abort at the next edge with no further strobe; the sequence restarts from DLY.

Verification
REQ-026 Reset release with an I2C model idling 50 cycles per write -> first wr_i2c at cycle START_DLY+2 with packet 24'h341E00; exactly 11 strobes; last packet 24'h341201; then init_done=1.
REQ-027 After init_done, vol_req with vol_val=7'h60 -> one strobe with packet 24'h340560, followed by a single vol_ack pulse.
REQ-028 I2C model never drops i2c_idle after the first strobe -> err=1 at ACK_TO cycles after the strobe, busy=0; a later start clears err and the first packet is 24'h341E00.
REQ-029 i2c_idle held 0 on entry to ISSUE for 30 cycles -> no strobe until i2c_idle rises, then strobe on the next edge.
REQ-030 reset=0 during WAIT_DONE of entry 5 -> all outputs reach reset values; after release the sequence restarts at entry 0.
REQ-031 start and vol_req asserted on the same cycle in DONE -> init sequence runs, no vol_ack; init_done=0 until the sequence completes.
